// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
package wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam logic [4:0]  REG_ZERO   = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CORE,
    GNT_MDU
  } grant_e;

  typedef enum logic {
    ST_NORMAL,
    ST_FORCE
  } state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO buffering {rd,data} MDU results until the write port is granted.
module wb_result_fifo #(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          push_ok, pop_ok;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign full  = full_q;
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between core writeback and buffered MDU results.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_wb_valid,
  input  logic [ADDR_W-1:0] core_wb_rd,
  input  logic [DATA_W-1:0] core_wb_data,
  output logic              core_wb_ready,
  output logic              core_stall,
  input  logic              mdu_wb_valid,
  input  logic [ADDR_W-1:0] mdu_wb_rd,
  input  logic [DATA_W-1:0] mdu_wb_data,
  output logic              mdu_wb_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mdu_pending
);

  localparam int unsigned EW  = ADDR_W + DATA_W;
  localparam int unsigned SCW = $clog2(STARVE_MAX + 1);

  logic              fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              mdu_push, mdu_pop, hazard;
  grant_e            grant;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              mdu_pending_q;
  logic [SCW-1:0]    starve_cnt_q, starve_cnt_d;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign {head_rd, head_data} = fifo_head;

  wb_result_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (mdu_push),
    .wdata ({mdu_wb_rd, mdu_wb_data}),
    .pop   (mdu_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // An older MDU result for the same register must land before the core's newer one.
  always_comb begin
    hazard = core_wb_valid & ~fifo_empty & (head_rd == core_wb_rd)
           & (core_wb_rd != ADDR_W'(REG_ZERO));
    grant = GNT_NONE;
    if (state_q == ST_FORCE && !fifo_empty) grant = GNT_MDU;
    else if (core_wb_valid && !hazard)      grant = GNT_CORE;
    else if (!fifo_empty)                   grant = GNT_MDU;
  end

  assign core_wb_ready = rst_n & core_wb_valid & (grant == GNT_CORE);
  assign core_stall    = core_wb_valid & ~core_wb_ready;
  assign mdu_wb_ready  = rst_n & ~fifo_full;
  assign mdu_push      = mdu_wb_valid & mdu_wb_ready;
  assign mdu_pop       = (grant == GNT_MDU);

  always_comb begin
    sel_rd     = (grant == GNT_MDU) ? head_rd   : core_wb_rd;
    sel_data   = (grant == GNT_MDU) ? head_data : core_wb_data;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant != GNT_NONE && sel_rd != ADDR_W'(REG_ZERO)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  // FORCE is entered on the edge where the count reaches the limit, so the
  // forced grant lands within STARVE_MAX+1 cycles of the FIFO going non-empty.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || grant == GNT_MDU)
      starve_cnt_d = '0;
    else if (grant == GNT_CORE && starve_cnt_q != SCW'(STARVE_MAX))
      starve_cnt_d = starve_cnt_q + SCW'(1);

    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (starve_cnt_d == SCW'(STARVE_MAX)) state_d = ST_FORCE;
      ST_FORCE:  if (grant == GNT_MDU || fifo_empty)  state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      mdu_pending_q <= 1'b0;
      starve_cnt_q  <= '0;
      state_q       <= ST_NORMAL;
    end else begin
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      mdu_pending_q <= ~fifo_empty;
      starve_cnt_q  <= starve_cnt_d;
      state_q       <= state_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign mdu_pending = mdu_pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every register-file write.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk, rst_n;
  logic        core_wb_valid, core_wb_ready, core_stall;
  logic [4:0]  core_wb_rd;
  logic [31:0] core_wb_data;
  logic        mdu_wb_valid, mdu_wb_ready;
  logic [4:0]  mdu_wb_rd;
  logic [31:0] mdu_wb_data;
  logic        rf_we, mdu_pending;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  regfile_wb_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_wb_valid (core_wb_valid),
    .core_wb_rd    (core_wb_rd),
    .core_wb_data  (core_wb_data),
    .core_wb_ready (core_wb_ready),
    .core_stall    (core_stall),
    .mdu_wb_valid  (mdu_wb_valid),
    .mdu_wb_rd     (mdu_wb_rd),
    .mdu_wb_data   (mdu_wb_data),
    .mdu_wb_ready  (mdu_wb_ready),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .mdu_pending   (mdu_pending)
  );

  typedef struct { int unsigned cyc; logic [4:0] rd; logic [31:0] data; } wr_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  wr_t         sb[$];
  ent_t        mq[$];
  int          lost;
  bit          pend;
  int          errors, checks;
  int unsigned cyc;
  logic [31:0] mrf [32];
  logic [31:0] drf [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT write must match the oldest predicted write, including its cycle.
  always @(posedge clk) begin
    wr_t w;
    cyc++;
    #1;
    if (rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none (cycle %0d)",
                 rf_waddr, rf_wdata, cyc);
      end else begin
        w = sb.pop_front();
        chk("write_cycle", 64'(cyc), 64'(w.cyc));
        chk("write_addr", 64'(rf_waddr), 64'(w.rd));
        chk("write_data", 64'(rf_wdata), 64'(w.data));
      end
      drf[rf_waddr] = rf_wdata;
    end
  end

  // One clock of stimulus; the model decides from queue contents and the starvation rule.
  task automatic cycle_io(input bit cv, input logic [4:0] crd, input logic [31:0] cd,
                          input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                          output bit cacc, output bit macc);
    bit   ne, haz, mdu_win, core_win, room;
    ent_t e;
    @(negedge clk);
    core_wb_valid = cv; core_wb_rd = crd; core_wb_data = cd;
    mdu_wb_valid  = mv; mdu_wb_rd  = mrd; mdu_wb_data  = md;
    #1;
    ne       = (mq.size() != 0);
    haz      = cv && ne && (mq[0].rd == crd) && (crd != 5'd0);
    mdu_win  = ne && (lost == SMAX || !cv || haz);
    core_win = cv && !mdu_win;
    room     = (mq.size() < DEPTH);
    chk("core_wb_ready", 64'(core_wb_ready), 64'(core_win));
    chk("core_stall", 64'(core_stall), 64'(cv && !core_win));
    chk("mdu_wb_ready", 64'(mdu_wb_ready), 64'(room));
    chk("mdu_pending", 64'(mdu_pending), 64'(pend));
    pend = ne;
    if (mdu_win) begin
      e = mq.pop_front();
      lost = 0;
      if (e.rd != 5'd0) begin
        sb.push_back('{cyc + 1, e.rd, e.data});
        mrf[e.rd] = e.data;
      end
    end else if (core_win) begin
      lost = ne ? ((lost < SMAX) ? lost + 1 : SMAX) : 0;
      if (crd != 5'd0) begin
        sb.push_back('{cyc + 1, crd, cd});
        mrf[crd] = cd;
      end
    end else begin
      lost = 0;
    end
    macc = mv && room;
    if (macc) mq.push_back('{mrd, md});
    cacc = core_win;
  endtask

  task automatic idle(input int n);
    bit c, m;
    for (int i = 0; i < n; i++) cycle_io(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, c, m);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_core_wb_ready", 64'(core_wb_ready), 64'd0);
    chk("rst_mdu_wb_ready", 64'(mdu_wb_ready), 64'd0);
    chk("rst_mdu_pending", 64'(mdu_pending), 64'd0);
  endtask

  initial begin
    bit c, m;
    int idx, n;
    errors = 0; checks = 0; cyc = 0; lost = 0; pend = 0;
    for (int i = 0; i < 32; i++) begin mrf[i] = '0; drf[i] = '0; end
    rst_n = 1'b0;
    core_wb_valid = 0; core_wb_rd = '0; core_wb_data = '0;
    mdu_wb_valid = 0; mdu_wb_rd = '0; mdu_wb_data = '0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Core-only writeback.
    cycle_io(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, c, m);
    idle(2);

    // Contention: one MDU result against a continuously busy core.
    cycle_io(1, 5'd3, 32'h300, 1, 5'd7, 32'h11, c, m);
    for (int i = 1; i < 10; i++) cycle_io(1, 5'd3, 32'h300 + i, 0, 5'd0, 32'd0, c, m);
    idle(2);

    // Full FIFO: three results pushed while the core stays busy.
    idx = 0;
    for (n = 0; n < 40 && idx < 3; n++) begin
      cycle_io(1, 5'd3, 32'h400 + n, 1, 5'(10 + idx), 32'h100 + idx, c, m);
      if (m) idx++;
    end
    chk("full_fifo_all_accepted", 64'(idx), 64'd3);
    idle(4);

    // Same-register hazard: the older MDU value lands before the core's.
    cycle_io(0, 5'd0, 32'd0, 1, 5'd9, 32'hA, c, m);
    c = 0;
    for (n = 0; n < 10 && !c; n++) cycle_io(1, 5'd9, 32'hB, 0, 5'd0, 32'd0, c, m);
    chk("hazard_core_accepted", 64'(c), 64'd1);
    idle(2);
    chk("hazard_final_x9", 64'(drf[9]), 64'hB);

    // x0 writes: handshakes complete, no register write.
    cycle_io(1, 5'd0, 32'h55, 0, 5'd0, 32'd0, c, m);
    chk("x0_core_accepted", 64'(c), 64'd1);
    cycle_io(0, 5'd0, 32'd0, 1, 5'd0, 32'h66, c, m);
    idle(3);

    // Reset with two results buffered.
    cycle_io(1, 5'd4, 32'h44, 1, 5'd12, 32'hC1, c, m);
    cycle_io(1, 5'd4, 32'h45, 1, 5'd13, 32'hC2, c, m);
    @(negedge clk);
    core_wb_valid = 0; mdu_wb_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    mq.delete(); sb.delete(); lost = 0; pend = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cycle_io(($urandom_range(99) < 60), 5'($urandom_range(31)), $urandom,
               ($urandom_range(99) < 35), 5'($urandom_range(31)), $urandom, c, m);
    end
    // Narrow register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      cycle_io(($urandom_range(99) < 75), 5'($urandom_range(3)), $urandom,
               ($urandom_range(99) < 50), 5'($urandom_range(3)), $urandom, c, m);
    end
    idle(8);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("regfile_x%0d", i), 64'(drf[i]), 64'(mrf[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two producers.
  - Core writeback: destination register from the write-register select mux, result from the ALU/load path.
  - Long-latency multiply/divide unit (MDU): results that return out of band.
- MDU results are buffered in a small FIFO. The core has priority, with a starvation guard for the MDU.
- Drives the registered write port and a stall to the core PC/pipeline control.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2)
- STARVE_MAX, 4, consecutive lost arbitration cycles before the MDU head is forced through

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_wb_valid  in  1  core has a writeback this cycle
- core_wb_rd  in  ADDR_W  core destination register
- core_wb_data  in  DATA_W  core writeback data
- core_wb_ready  out  1  core writeback accepted this cycle
- core_stall  out  1  core must hold its state (core_wb_valid & ~core_wb_ready)
- mdu_wb_valid  in  1  MDU result valid
- mdu_wb_rd  in  ADDR_W  MDU destination register
- mdu_wb_data  in  DATA_W  MDU result
- mdu_wb_ready  out  1  FIFO can accept (= ~full)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- mdu_pending  out  1  FIFO non-empty

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rf_we/rf_waddr/rf_wdata = 0, core_wb_ready = 0, mdu_wb_ready = 0, mdu_pending = 0.
  - Internal: FIFO pointers/count = 0, starve_cnt = 0, state = NORMAL.
  - Reset mid-operation discards all buffered MDU results.
- MDU push: on mdu_wb_valid & mdu_wb_ready.
  - mdu_wb_ready depends only on the registered full flag; there is no pop-to-push combinational path.
  - A full FIFO refuses the push even if a pop occurs in the same cycle.
- Grant, combinational per cycle:
  - state FORCE and FIFO non-empty -> grant MDU head.
  - Else core_wb_valid -> grant core.
  - Else FIFO non-empty -> grant MDU head.
  - Else no grant.
- Same-register ordering: if core_wb_valid and the FIFO head rd equal the same nonzero register, grant the MDU head first. The older result is written first and the core write lands later and wins.
- core_wb_ready = core_wb_valid & (grant==core). core_stall holds until granted.
- Write port: one-cycle latency. The granted request drives rf_we/rf_waddr/rf_wdata on the next clk edge.
  - rd==0: rf_we=0 and rf_waddr/rf_wdata hold their values.
  - The handshake and FIFO pop still complete (x0 is never written).
  - rf_we=0 when there is no grant.
- FIFO pop: when the MDU is granted. Push and pop in the same cycle when not full: count unchanged, both pointers advance, pointers wrap modulo FIFO_DEPTH.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when the FIFO is non-empty and the core is granted.
  - Clears on an MDU grant or when the FIFO is empty.
- FSM:
  - NORMAL -> FORCE when starve_cnt==STARVE_MAX.
  - FORCE -> NORMAL after exactly one MDU grant.
  - FORCE with the FIFO empty (only after reset/flush) -> NORMAL.
- Within any STARVE_MAX+1 cycle window with the FIFO non-empty, at least one MDU result retires.
- mdu_pending is registered from count!=0.

Decomposition:
- Shared package (wb_pkg): DATA_W/ADDR_W defaults, REG_ZERO constant (5'd0), grant enum {GNT_NONE, GNT_CORE, GNT_MDU}, FSM state enum {ST_NORMAL, ST_FORCE}.
- Sub-module wb_result_fifo: synchronous FIFO, {rd,data} entries, outputs full/empty/head, async active-low reset.
- Arbitration, FSM, starvation counter and the output register stay in regfile_wb_arbiter.

Test Plan:
- Core only: core_wb_valid=1 rd=5 data=0xDEADBEEF -> core_wb_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; core_stall=0 throughout.
- Contention: MDU pushes rd=7 data=0x11; core valid rd=3 for 10 cycles -> core granted 4 cycles, cycle 5 MDU forced (rf_waddr=7, rf_wdata=0x11), core_stall=1 for exactly that cycle, then core resumes.
- Full FIFO: 3 back-to-back MDU pushes with core busy -> mdu_wb_ready=0 after 2 accepted; third held until a pop; all 3 results retire in order.
- Same-rd hazard: FIFO head rd=9 data=0xA, core rd=9 data=0xB the same cycle -> write 0xA then 0xB; final x9=0xB.
- x0 write: core rd=0 -> core_wb_ready=1, rf_we stays 0; MDU rd=0 pops with rf_we=0.
- Reset mid-operation: 2 entries buffered, rst_n low for one cycle asynchronously -> all outputs 0 immediately, mdu_pending=0, no stale write after release.
